// File: rtl/uart_sched_pkg.sv
// Shared definitions for the UART TX scheduler: drain FSM state encoding and
// the requester-ID width helper.
package uart_sched_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } sched_state_e;

  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, wrapping
// modulo NREQ (NREQ need not be a power of two).
module rr_arbiter
  import uart_sched_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0]           req,
  input  logic [id_width(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]           gnt,
  output logic [id_width(NREQ)-1:0] gnt_idx,
  output logic                      any_grant
);

  localparam int unsigned IDW = id_width(NREQ);

  logic [IDW:0] cand;

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    any_grant = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!any_grant && req[cand[IDW-1:0]]) begin
        any_grant             = 1'b1;
        gnt[cand[IDW-1:0]]    = 1'b1;
        gnt_idx               = cand[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between NREQ one-byte requesters with one-deep
// slots and a round-robin drain FSM. Optional start-ack timeout: UART_SCHED_TIMEOUT_EN.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int unsigned N         = 8,
  parameter int unsigned NREQ      = 2,
  parameter int unsigned TO_CYCLES = 1023
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*N-1:0]         req_data,
  output logic [NREQ-1:0]           req_busy,
  output logic [NREQ-1:0]           req_done,
  output logic                      uart_start,
  output logic [N-1:0]              uart_data,
  input  logic                      uart_busy,
  output logic                      ovf,
`ifdef UART_SCHED_TIMEOUT_EN
  output logic                      timeout_err,
`endif
  output logic [$clog2(NREQ)-1:0]   active_id
);

  localparam int unsigned IDW = id_width(NREQ);

  if (TO_CYCLES < 1 || TO_CYCLES > 2047) begin : g_to_range
    $error("TO_CYCLES must fit the 11-bit start-acknowledge counter");
  end

  sched_state_e              state_q, state_d;
  logic [NREQ-1:0]           slot_valid_q, slot_valid_d;
  logic [NREQ-1:0][N-1:0]    slot_data_q, slot_data_d;
  logic [IDW-1:0]            ptr_q, ptr_d;
  logic [IDW-1:0]            active_q, active_d;
  logic [N-1:0]              uart_data_q, uart_data_d;
  logic [NREQ-1:0]           done_q, done_d;
  logic                      ovf_q, ovf_d;
  logic [NREQ-1:0]           clr;
  logic                      finish;
  logic [NREQ-1:0]           gnt;
  logic [IDW-1:0]            gnt_idx;
  logic                      any_grant;
`ifdef UART_SCHED_TIMEOUT_EN
  localparam logic [10:0] TO_LAST = 11'(TO_CYCLES - 1);
  logic [10:0]               to_cnt_q, to_cnt_d;
  logic                      to_err_q, to_err_d;
`endif

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req       (slot_valid_q),
    .ptr       (ptr_q),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .any_grant (any_grant)
  );

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    active_d     = active_q;
    uart_data_d  = uart_data_q;
    done_d       = '0;
    ovf_d        = ovf_q;
    slot_valid_d = slot_valid_q;
    slot_data_d  = slot_data_q;
    clr          = '0;
    finish       = 1'b0;
`ifdef UART_SCHED_TIMEOUT_EN
    to_cnt_d     = '0;
    to_err_d     = to_err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (any_grant && !uart_busy) begin
          active_d    = gnt_idx;
          uart_data_d = slot_data_q[gnt_idx];
          state_d     = START;
        end
      end
      START: state_d = WAIT_ACK;
      WAIT_ACK: begin
        if (uart_busy) begin
          state_d = WAIT_DONE;
`ifdef UART_SCHED_TIMEOUT_EN
        end else if (to_cnt_q == TO_LAST) begin
          finish   = 1'b1;
          to_err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 11'd1;
`endif
        end
      end
      WAIT_DONE: if (!uart_busy) finish = 1'b1;
      default: state_d = IDLE;
    endcase

    if (finish) begin
      clr[active_q]    = 1'b1;
      done_d[active_q] = 1'b1;
      ptr_d            = (active_q == IDW'(NREQ - 1)) ? '0 : active_q + IDW'(1);
      state_d          = IDLE;
    end

    // A slot freed this cycle accepts a new byte on the same edge without ovf.
    for (int unsigned i = 0; i < NREQ; i++) begin
      slot_valid_d[i] = slot_valid_q[i] & ~clr[i];
      if (req_valid[i]) begin
        if (slot_valid_d[i]) begin
          ovf_d = 1'b1;
        end else begin
          slot_valid_d[i] = 1'b1;
          slot_data_d[i]  = req_data[i*N +: N];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      active_q     <= '0;
      uart_data_q  <= '0;
      done_q       <= '0;
      ovf_q        <= 1'b0;
      slot_valid_q <= '0;
      slot_data_q  <= '0;
`ifdef UART_SCHED_TIMEOUT_EN
      to_cnt_q     <= '0;
      to_err_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      active_q     <= active_d;
      uart_data_q  <= uart_data_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
      slot_valid_q <= slot_valid_d;
      slot_data_q  <= slot_data_d;
`ifdef UART_SCHED_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
      to_err_q     <= to_err_d;
`endif
    end
  end

  assign req_busy   = slot_valid_q;
  assign req_done   = done_q;
  assign uart_start = (state_q == START);
  assign uart_data  = uart_data_q;
  assign ovf        = ovf_q;
  assign active_id  = active_q;
`ifdef UART_SCHED_TIMEOUT_EN
  assign timeout_err = to_err_q;
`endif

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Shares the single external UART transmitter between NREQ bus-side requesters, each a bus-to-UART bridge slave that pulses a one-byte transmit request. Each requester gets a one-deep holding slot. A round-robin drain FSM feeds the held bytes to the UART one at a time and returns per-requester busy/done handshakes. It sits between the bridge slaves' tx_external/to_uart/uart_busy/end_tx pins and the UART TX module.

Parameters:
N, 8, data byte width
NREQ, 2, number of requesters (>=2)
TO_CYCLES, 1023, start-acknowledge timeout in clk cycles (used only with the optional feature)

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  reset, asynchronous, active-low
req_valid  input  NREQ  per-requester one-cycle transmit pulse (bridge tx_external)
req_data  input  NREQ*N  requester i's byte at bits [i*N +: N]
req_busy  output  NREQ  1 = slot i occupied; drives the bridge's uart_busy
req_done  output  NREQ  one-cycle pulse when slot i's byte has finished on the UART (bridge end_tx)
uart_start  output  1  one-cycle start strobe to the UART TX
uart_data  output  N  byte to transmit, stable from uart_start until the byte completes
uart_busy  input  1  UART TX busy
ovf  output  1  sticky: a request arrived while its slot was full
active_id  output  $clog2(NREQ)  requester currently being served

Behaviour:
- Reset (async, reset_n=0): all slots empty; req_busy=0, req_done=0, uart_start=0, uart_data=0, ovf=0, active_id=0; RR pointer=0; FSM=IDLE. Assertion mid-transfer aborts immediately. Nothing is replayed after release.
- Slot capture: req_valid[i] with slot i empty loads req_data[i] and sets slot_valid[i] on that edge. req_busy[i]=slot_valid[i], registered, so it rises the cycle after capture.
- All requesters can capture in the same cycle.
- req_valid[i] with slot i full drops the byte, leaves the slot unchanged, and sets ovf. ovf clears only on reset.
- FSM states:
  - IDLE: if any slot is valid and uart_busy=0, grant the first valid slot at or after the RR pointer (wrapping). Latch uart_data and active_id, then go to START.
  - START: uart_start=1 for exactly one cycle, then go to WAIT_ACK.
  - WAIT_ACK: wait for uart_busy=1, then go to WAIT_DONE.
  - WAIT_DONE: wait for uart_busy=0. Then clear slot[active_id], pulse req_done[active_id] for one cycle, set RR pointer=(active_id+1) mod NREQ, and go to IDLE.
- Latency: capture edge to uart_start high is 2 cycles minimum (capture, IDLE grant, START).
- Slot clear and a new req_valid on the same requester in the same cycle: the clear wins for the old byte, and the new byte is captured (no ovf).
- A slot valid at the start of a grant cycle is never granted twice.
- uart_busy=1 while in IDLE: hold off granting.
- Fairness: with all slots continuously refilled, grants strictly rotate 0,1,...,NREQ-1.
- RR pointer arithmetic wraps modulo NREQ; NREQ need not be a power of two.

Optional Feature:
UART_SCHED_TIMEOUT_EN
- Defined: an 11-bit counter runs in WAIT_ACK. If it reaches TO_CYCLES without uart_busy=1, the FSM:
  - returns to IDLE;
  - clears the slot;
  - pulses req_done[active_id];
  - sets a sticky output port timeout_err (1 bit, reset 0).
- Undefined: WAIT_ACK waits indefinitely. timeout_err and the counter are absent.

Decomposition:
- Shared package uart_sched_pkg holds:
  - state encodings IDLE=2'd0, START=2'd1, WAIT_ACK=2'd2, WAIT_DONE=2'd3;
  - a clog2-based ID width helper.
- Sub-module rr_arbiter (NREQ): combinational priority rotate from request vector and pointer, producing a grant one-hot, a grant index, and any_grant.

Test Plan:
- Single request: reset, then req_valid[0] with data 8'hA5.
  - req_busy[0]=1 next cycle.
  - uart_start pulses 2 cycles after capture with uart_data=8'hA5.
  - Model uart_busy high for 10 cycles, then low: req_done[0] pulses once, req_busy[0]=0.
- Simultaneous requests: req_valid=2'b11 with bytes 8'h11/8'h22 in the same cycle.
  - Both captured.
  - UART sees 8'h11 then 8'h22; req_done[0] precedes req_done[1].
- Fairness: keep both slots refilled on every req_done.
  - 6 consecutive grants alternate 0,1,0,1,0,1.
- Overflow: req_valid[1] (8'h33), then req_valid[1] (8'h44) while slot 1 is full.
  - ovf=1; UART transmits 8'h33 only.
  - ovf stays 1 until reset.
- Reset mid-operation: assert reset_n=0 in WAIT_DONE.
  - Outputs clear asynchronously, slots empty, FSM=IDLE.
  - No req_done pulse after release.
- Timeout (with UART_SCHED_TIMEOUT_EN, TO_CYCLES=16): hold uart_busy=0 after uart_start.
  - After 16 cycles: req_done pulses, timeout_err=1, FSM=IDLE.
